// File: rtl/conv_pkg.sv
// Shared defaults, derived widths and controller state encoding for the
// 1-D convolution MAC controller.
package conv_pkg;

  localparam int unsigned N_DEF = 30;
  localparam int unsigned M_DEF = 9;
  localparam int unsigned T_DEF = 11;

  localparam int unsigned XA_W  = $clog2(N_DEF);
  localparam int unsigned FA_W  = $clog2(M_DEF);
  localparam int unsigned ACC_W = 2 * T_DEF + $clog2(M_DEF);

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    OUT     = 2'd2
  } state_e;

endpackage

// File: rtl/conv_mac_ctrl_if.sv
// Sample stream, coefficient ROM port and result stream of conv_mac_ctrl.
// slave is the controller side; master is the surrounding environment.
interface conv_mac_ctrl_if
  import conv_pkg::*;
#(
  parameter int unsigned T   = T_DEF,
  parameter int unsigned FAW = FA_W
) ();

  logic signed [T-1:0]   s_data_in;
  logic                  s_valid;
  logic                  s_ready;
  logic [FAW-1:0]        f_addr;
  logic signed [T-1:0]   f_data;
  logic signed [T-1:0]   m_data_out;
  logic                  m_valid;
  logic                  m_ready;

  modport slave (
    input  s_data_in, s_valid, f_data, m_ready,
    output s_ready, f_addr, m_data_out, m_valid
  );

  modport master (
    output s_data_in, s_valid, f_data, m_ready,
    input  s_ready, f_addr, m_data_out, m_valid
  );

endinterface

// File: rtl/conv_xmem.sv
// Input sample buffer: N words of T bits, one write port and one read port
// whose data appears one cycle after the address.
module conv_xmem
  import conv_pkg::*;
#(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned T  = T_DEF,
  parameter int unsigned AW = XA_W
) (
  input  logic                clk,
  input  logic                we_i,
  input  logic [AW-1:0]       wr_addr_i,
  input  logic signed [T-1:0] wr_data_i,
  input  logic [AW-1:0]       rd_addr_i,
  output logic signed [T-1:0] rd_data_o
);

  logic signed [T-1:0] mem_q [N];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[wr_addr_i] <= wr_data_i;
    rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/conv_mac_ctrl.sv
// Valid-mode 1-D convolution controller: buffers N samples, then streams
// N-M+1 ReLU-saturated M-tap dot products against an external coefficient ROM.
module conv_mac_ctrl
  import conv_pkg::*;
#(
  parameter int unsigned N = N_DEF,
  parameter int unsigned M = M_DEF,
  parameter int unsigned T = T_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  conv_mac_ctrl_if.slave  bus
);

  localparam int unsigned XAW    = $clog2(N);
  localparam int unsigned FAW    = $clog2(M);
  localparam int unsigned PW     = 2 * T;
  localparam int unsigned AW     = 2 * T + $clog2(M);
  localparam int unsigned CW     = $clog2(M + 2);
  localparam int unsigned LAST_J = N - M;
  localparam logic signed [AW-1:0] SAT_MAX = AW'((1 << (T - 1)) - 1);

  state_e               state_q;
  logic [XAW-1:0]       wr_ptr_q;
  logic [XAW-1:0]       j_q;
  logic [FAW-1:0]       f_addr_q;
  logic [CW-1:0]        cnt_q;
  logic signed [AW-1:0] acc_q;
  logic                 s_ready_q;
  logic                 m_valid_q;
  logic signed [T-1:0]  m_data_q;

  logic                 x_we_c;
  logic [XAW-1:0]       x_rd_addr_c;
  logic signed [T-1:0]  x_rd;
  logic signed [PW-1:0] prod_c;
  logic                 acc_en_c;

  // ReLU followed by clamp to the largest positive T-bit value.
  function automatic logic signed [T-1:0] relu_sat(input logic signed [AW-1:0] a);
    if (a[AW-1])          return '0;
    else if (a > SAT_MAX) return T'(SAT_MAX);
    else                  return a[T-1:0];
  endfunction

  assign x_we_c      = (state_q == LOAD) && s_ready_q && bus.s_valid;
  assign x_rd_addr_c = j_q + XAW'(f_addr_q);
  assign prod_c      = PW'(x_rd) * PW'(bus.f_data);
  // Tap k is addressed in cycle k after entry and its product lands at count k+1.
  assign acc_en_c    = (cnt_q >= CW'(1)) && (cnt_q <= CW'(M));

  conv_xmem #(
    .N  (N),
    .T  (T),
    .AW (XAW)
  ) u_xmem (
    .clk       (clk),
    .we_i      (x_we_c),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (bus.s_data_in),
    .rd_addr_i (x_rd_addr_c),
    .rd_data_o (x_rd)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= LOAD;
      wr_ptr_q  <= '0;
      j_q       <= '0;
      f_addr_q  <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (x_we_c) begin
            if (wr_ptr_q == XAW'(N - 1)) begin
              state_q   <= COMPUTE;
              s_ready_q <= 1'b0;
              j_q       <= '0;
              f_addr_q  <= '0;
              cnt_q     <= '0;
              acc_q     <= '0;
            end else begin
              wr_ptr_q <= wr_ptr_q + XAW'(1);
            end
          end
        end
        COMPUTE: begin
          cnt_q <= cnt_q + CW'(1);
          if (f_addr_q != FAW'(M - 1)) f_addr_q <= f_addr_q + FAW'(1);
          if (acc_en_c) acc_q <= acc_q + AW'(prod_c);
          if (cnt_q == CW'(M + 1)) begin
            m_valid_q <= 1'b1;
            m_data_q  <= relu_sat(acc_q);
            state_q   <= OUT;
          end
        end
        OUT: begin
          if (bus.m_ready) begin
            m_valid_q <= 1'b0;
            if (j_q < XAW'(LAST_J)) begin
              j_q      <= j_q + XAW'(1);
              state_q  <= COMPUTE;
              f_addr_q <= '0;
              cnt_q    <= '0;
              acc_q    <= '0;
            end else begin
              wr_ptr_q  <= '0;
              s_ready_q <= 1'b1;
              state_q   <= LOAD;
            end
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign bus.s_ready    = s_ready_q;
  assign bus.f_addr     = f_addr_q;
  assign bus.m_data_out = m_data_q;
  assign bus.m_valid    = m_valid_q;

endmodule

// File: doc/conv_mac_ctrl.md
CONV_MAC_CTRL -- requirements
Module: conv_mac_ctrl

Interface
REQ-001 SHALL have parameter N, default 30, input vector length in words.
REQ-002 SHALL have parameter M, default 9, filter taps (fmem depth).
REQ-003 SHALL have parameter T, default 11, signed data/coefficient width in bits.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 port: clk  input  1  rising-edge clock.
REQ-006 port: reset_n  input  1  asynchronous active-low reset.
REQ-007 port: s_data_in  input  T  signed input sample.
REQ-008 port: s_valid  input  1  s_data_in valid.
REQ-009 port: s_ready  output  1  block accepts a sample this cycle.
REQ-010 port: f_addr  output  $clog2(M) (4 for M=9)  fmem coefficient address.
REQ-011 port: f_data  input  T  signed coefficient; registered ROM, valid 1 cycle after f_addr.
REQ-012 port: m_data_out  output  T  result word.
REQ-013 port: m_valid  output  1  m_data_out valid.
REQ-014 port: m_ready  input  1  downstream accepts result.

Function
REQ-015 FSM states SHALL be LOAD, COMPUTE, OUT.
REQ-016 LOAD: s_ready=1; each cycle with s_valid&&s_ready writes s_data_in to xmem[wr_ptr], wr_ptr++.
REQ-017 On the N-th accepted sample, SHALL go to COMPUTE with j=0; s_ready=0 from the next cycle.
REQ-018 COMPUTE for output j: cycles k=0..M-1 drive f_addr=k and xmem read address j+k; both reads return 1 cycle later.
REQ-019 Accumulator SHALL clear on COMPUTE entry and add the signed product x*f (2T bits) once per returned tap; accumulator width 2T+$clog2(M).
REQ-020 After the M-th product is accumulated, the result register SHALL load: 0 if acc<0; 2^(T-1)-1 if acc>2^(T-1)-1; else acc[T-1:0].
REQ-021 m_valid SHALL rise on the (M+2)-th rising edge after COMPUTE entry; state becomes OUT.
REQ-022 OUT: m_data_out and m_valid held stable while m_ready=0.
REQ-023 OUT handshake (m_valid&&m_ready): m_valid drops next cycle; if j<N-M then j++ and COMPUTE, else wr_ptr=0 and LOAD.
REQ-024 SHALL produce exactly N-M+1 outputs per N-sample vector, in order j=0..N-M.
REQ-025 s_valid outside LOAD SHALL be ignored (s_ready=0); no xmem write.
REQ-026 f_addr SHALL never exceed M-1; xmem address never exceeds N-1.
REQ-027 m_ready asserted while m_valid=0 SHALL have no effect.

Reset
REQ-028 reset_n=0 SHALL immediately force state=LOAD, wr_ptr=0, j=0, acc=0, m_valid=0, m_data_out=0, f_addr=0; s_ready=1 after release.
REQ-029 Reset mid-COMPUTE or mid-OUT SHALL discard partial vector and results; xmem contents need not clear.

Structure
REQ-030 Shared package conv_pkg SHALL hold N, M, T defaults, derived widths (address, accumulator), and state enum.
REQ-031 Input buffer SHALL be sub-module conv_xmem: N x T, one write port, one registered read port.
REQ-032 fmem ROM SHALL be instantiated outside this block and connected via f_addr/f_data.

Verification (bench uses fmem stub with all taps = 1, N=30, M=9, T=11)
REQ-033 30 samples of 100, m_ready=1 -> 22 outputs of 900, each m_valid 11 cycles after COMPUTE entry.
REQ-034 30 samples of 1023 -> 22 outputs of 1023 (saturated from 9207).
REQ-035 30 samples of -5 -> 22 outputs of 0 (ReLU).
REQ-036 m_ready low 5 cycles in OUT -> m_data_out/m_valid constant, s_ready=0, no extra outputs.
REQ-037 reset_n pulsed mid-COMPUTE -> m_valid=0 immediately, s_ready=1 after release, next 30 samples of 100 give 22 outputs of 900.
REQ-038 s_valid held high during COMPUTE/OUT with changing data -> results unaffected.
